// File: rtl/tile_flasher_if.sv
// Bundle between the sequence controller / lookup stage and the tile flasher,
// including the pixel-write side that feeds the VGA adapter.
interface tile_flasher_if;
    logic       start;
    logic [7:0] tile_x;
    logic [6:0] tile_y;
    logic [2:0] tile_colour;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        output start, tile_x, tile_y, tile_colour,
        input  x_out, y_out, colour_out, plot, busy, done
    );

    modport slave (
        input  start, tile_x, tile_y, tile_colour,
        output x_out, y_out, colour_out, plot, busy, done
    );
endinterface

// File: rtl/tile_flasher.sv
// Paints an 8x8 tile one pixel per clock, holds it lit, repaints it in the
// off colour and pulses done. Every output is a register.
module tile_flasher #(
    parameter int         HOLD_CYCLES = 25000000,
    parameter logic [2:0] OFF_COLOUR  = 3'b000
) (
    input logic          clock,
    input logic          resetn,
    tile_flasher_if.slave bus
);

    typedef enum logic [2:0] {IDLE, DRAW_ON, HOLD, DRAW_OFF, DONE} state_t;

    localparam logic [25:0] HOLD_LAST = 26'(HOLD_CYCLES - 1);

    state_t      state, state_n;
    logic [5:0]  cnt, cnt_n;
    logic [25:0] hold_cnt, hold_cnt_n;
    logic [7:0]  lx, lx_n;
    logic [6:0]  ly, ly_n;
    logic [2:0]  lc, lc_n;
    logic [7:0]  x_q, x_n;
    logic [6:0]  y_q, y_n;
    logic [2:0]  col_q, col_n;
    logic        plot_q, plot_n;
    logic        busy_q;
    logic        done_q, done_n;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            hold_cnt <= '0;
            lx       <= '0;
            ly       <= '0;
            lc       <= '0;
            x_q      <= '0;
            y_q      <= '0;
            col_q    <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            hold_cnt <= hold_cnt_n;
            lx       <= lx_n;
            ly       <= ly_n;
            lc       <= lc_n;
            x_q      <= x_n;
            y_q      <= y_n;
            col_q    <= col_n;
            plot_q   <= plot_n;
            busy_q   <= (state_n != IDLE);
            done_q   <= done_n;
        end
    end

    // Outputs are computed for the pixel the counter will hold next cycle,
    // so the registered coordinates line up with the registered plot strobe.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        hold_cnt_n = hold_cnt;
        lx_n       = lx;
        ly_n       = ly;
        lc_n       = lc;
        x_n        = x_q;
        y_n        = y_q;
        col_n      = col_q;
        plot_n     = 1'b0;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    lx_n    = bus.tile_x;
                    ly_n    = bus.tile_y;
                    lc_n    = bus.tile_colour;
                    cnt_n   = '0;
                    state_n = DRAW_ON;
                    plot_n  = 1'b1;
                    x_n     = bus.tile_x;
                    y_n     = bus.tile_y;
                    col_n   = bus.tile_colour;
                end
            end
            DRAW_ON: begin
                if (cnt == 6'd63) begin
                    state_n    = HOLD;
                    cnt_n      = '0;
                    hold_cnt_n = '0;
                end else begin
                    cnt_n  = cnt + 6'd1;
                    plot_n = 1'b1;
                    x_n    = lx + {5'b0, cnt_n[2:0]};
                    y_n    = ly + {4'b0, cnt_n[5:3]};
                    col_n  = lc;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_n = DRAW_OFF;
                    cnt_n   = '0;
                    plot_n  = 1'b1;
                    x_n     = lx;
                    y_n     = ly;
                    col_n   = OFF_COLOUR;
                end else begin
                    hold_cnt_n = hold_cnt + 26'd1;
                end
            end
            DRAW_OFF: begin
                if (cnt == 6'd63) begin
                    state_n = DONE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n  = cnt + 6'd1;
                    plot_n = 1'b1;
                    x_n    = lx + {5'b0, cnt_n[2:0]};
                    y_n    = ly + {4'b0, cnt_n[5:3]};
                    col_n  = OFF_COLOUR;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.x_out      = x_q;
    assign bus.y_out      = y_q;
    assign bus.colour_out = col_q;
    assign bus.plot       = plot_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_tile_flasher.sv
// Self-checking bench for tile_flasher: a cycle-index model of one flash is
// compared with the DUT every cycle, plus literal checks of directed scenarios.
module tb_tile_flasher;
    localparam int H         = 4;
    localparam int FLASH_LEN = 136 + H;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    tile_flasher_if bus();

    tile_flasher #(.HOLD_CYCLES(H), .OFF_COLOUR(3'b000)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: n is the cycle number within the current flash (0 = never started).
    int n  = 0;
    int bx = 0;
    int by = 0;
    int bc = 0;

    int obs_x    [1:300];
    int obs_y    [1:300];
    int obs_col  [1:300];
    int obs_plot [1:300];
    int obs_busy [1:300];
    int obs_done [1:300];

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            n = 0;
        end else if ((n == 0 || n >= 130 + H) && bus.start) begin
            bx = int'(bus.tile_x);
            by = int'(bus.tile_y);
            bc = int'(bus.tile_colour);
            n  = 1;
        end else if (n >= 1 && n < 130 + H) begin
            n = n + 1;
        end
    end

    always @(negedge clock) begin
        int  p;
        bit  lit_phase, off_phase;
        if (!resetn) begin
            check_output("reset_x", int'(bus.x_out), 0);
            check_output("reset_y", int'(bus.y_out), 0);
            check_output("reset_colour", int'(bus.colour_out), 0);
            check_output("reset_plot", int'(bus.plot), 0);
            check_output("reset_busy", int'(bus.busy), 0);
            check_output("reset_done", int'(bus.done), 0);
        end else begin
            lit_phase = (n >= 1 && n <= 64);
            off_phase = (n >= 65 + H && n <= 128 + H);
            check_output("plot", int'(bus.plot), int'(lit_phase || off_phase));
            check_output("busy", int'(bus.busy), int'(n >= 1 && n <= 129 + H));
            check_output("done", int'(bus.done), int'(n == 129 + H));
            if (lit_phase || off_phase) begin
                p = lit_phase ? n - 1 : n - 65 - H;
                check_output("pixel_x", int'(bus.x_out), (bx + p % 8) % 256);
                check_output("pixel_y", int'(bus.y_out), (by + p / 8) % 128);
                check_output("pixel_colour", int'(bus.colour_out), lit_phase ? bc : 0);
            end
        end
    end

    function automatic int count_plots();
        int total = 0;
        for (int c = 1; c <= FLASH_LEN; c++) total += obs_plot[c];
        return total;
    endfunction

    function automatic int count_dones();
        int total = 0;
        for (int c = 1; c <= FLASH_LEN; c++) total += obs_done[c];
        return total;
    endfunction

    // mode 0: plain flash; mode 1: disturb inputs and pulse start while busy;
    // mode 2: assert reset in cycle 40 and abandon the flash.
    task automatic run_flash(input logic [7:0] tx, input logic [6:0] ty,
                             input logic [2:0] tc, input int mode);
        @(negedge clock);
        bus.tile_x      = tx;
        bus.tile_y      = ty;
        bus.tile_colour = tc;
        bus.start       = 1'b1;
        for (int c = 1; c <= FLASH_LEN; c++) begin
            @(negedge clock);
            obs_x[c]    = int'(bus.x_out);
            obs_y[c]    = int'(bus.y_out);
            obs_col[c]  = int'(bus.colour_out);
            obs_plot[c] = int'(bus.plot);
            obs_busy[c] = int'(bus.busy);
            obs_done[c] = int'(bus.done);
            if (c == 1) bus.start = 1'b0;
            if (mode == 1) begin
                if (c == 10) begin
                    bus.tile_x      = 8'd0;
                    bus.tile_y      = 7'd8;
                    bus.tile_colour = 3'b011;
                end
                if (c == 30 || c == 70) bus.start = 1'b1;
                if (c == 31 || c == 71) bus.start = 1'b0;
            end
            if (mode == 2 && c == 40) begin
                #1 resetn = 1'b0;
                #1;
                check_output("midreset_plot_drop", int'(bus.plot), 0);
                check_output("midreset_busy_drop", int'(bus.busy), 0);
                repeat (3) @(negedge clock);
                #1 resetn = 1'b1;
                return;
            end
        end
    endtask

    task automatic apply_stimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            bus.start       = ($urandom_range(0, 5) == 0);
            bus.tile_x      = 8'($urandom);
            bus.tile_y      = 7'($urandom);
            bus.tile_colour = 3'($urandom);
        end
        @(negedge clock);
        bus.start = 1'b0;
        repeat (150) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, time %0t, required below 1000000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn          = 1'b0;
        bus.start       = 1'b1;
        bus.tile_x      = 8'd33;
        bus.tile_y      = 7'd17;
        bus.tile_colour = 3'b111;
        repeat (10) @(negedge clock);
        check_output("reset_hold_plot", int'(bus.plot), 0);
        bus.start = 1'b0;
        #1 resetn = 1'b1;
        repeat (5) @(negedge clock);
        check_output("idle_no_start_plot", int'(bus.plot), 0);
        check_output("idle_no_start_busy", int'(bus.busy), 0);

        // Basic flash with input disturbance and ignored start pulses
        run_flash(8'd8, 7'd0, 3'b010, 1);
        check_output("basic_c1_x", obs_x[1], 8);
        check_output("basic_c1_y", obs_y[1], 0);
        check_output("basic_c1_colour", obs_col[1], 2);
        check_output("stable_c11_x", obs_x[11], 10);
        check_output("stable_c11_y", obs_y[11], 1);
        check_output("stable_c11_colour", obs_col[11], 2);
        check_output("basic_c64_x", obs_x[64], 15);
        check_output("basic_c64_y", obs_y[64], 7);
        check_output("basic_c65_plot", obs_plot[65], 0);
        check_output("basic_c68_plot", obs_plot[68], 0);
        check_output("basic_c69_plot", obs_plot[69], 1);
        check_output("basic_c69_colour", obs_col[69], 0);
        check_output("basic_c132_x", obs_x[132], 15);
        check_output("basic_c132_done", obs_done[132], 0);
        check_output("basic_c133_done", obs_done[133], 1);
        check_output("basic_c134_busy", obs_busy[134], 0);
        check_output("basic_plot_count", count_plots(), 128);
        check_output("basic_done_count", count_dones(), 1);

        // Coordinate wrap-around
        run_flash(8'd252, 7'd124, 3'b100, 0);
        check_output("wrap_p4_x", obs_x[5], 0);
        check_output("wrap_p32_x", obs_x[33], 252);
        check_output("wrap_p32_y", obs_y[33], 0);
        check_output("wrap_p63_x", obs_x[64], 3);
        check_output("wrap_p63_y", obs_y[64], 3);
        check_output("wrap_colour", obs_col[64], 4);

        // Reset mid-draw, then a fresh flash with unchanged timing
        run_flash(8'd8, 7'd0, 3'b010, 2);
        run_flash(8'd0, 7'd0, 3'b001, 0);
        check_output("fresh_c1_x", obs_x[1], 0);
        check_output("fresh_c1_plot", obs_plot[1], 1);
        check_output("fresh_c1_colour", obs_col[1], 1);
        check_output("fresh_c64_y", obs_y[64], 7);
        check_output("fresh_c133_done", obs_done[133], 1);
        check_output("fresh_c134_busy", obs_busy[134], 0);
        check_output("fresh_plot_count", count_plots(), 128);

        // start held high: back-to-back flashes
        @(negedge clock);
        bus.tile_x      = 8'd16;
        bus.tile_y      = 7'd8;
        bus.tile_colour = 3'b101;
        bus.start       = 1'b1;
        for (int c = 1; c <= 131 + H; c++) begin
            @(negedge clock);
            obs_plot[c] = int'(bus.plot);
            obs_busy[c] = int'(bus.busy);
            obs_done[c] = int'(bus.done);
            obs_x[c]    = int'(bus.x_out);
            obs_col[c]  = int'(bus.colour_out);
        end
        bus.start = 1'b0;
        check_output("held_done", obs_done[129 + H], 1);
        check_output("held_idle_busy", obs_busy[130 + H], 0);
        check_output("held_restart_plot", obs_plot[131 + H], 1);
        check_output("held_restart_x", obs_x[131 + H], 16);
        check_output("held_restart_colour", obs_col[131 + H], 5);
        repeat (FLASH_LEN) @(negedge clock);

        apply_stimulus(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
